// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, divider state encoding and counter sizing helper.
package cpu_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step, compared in WIDTH+1 bits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] shifted, diff;
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = shifted >= {1'b0, divisor};
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end
endmodule

// File: rtl/divider_unit.sv
// divider_unit: iterative restoring div/divu, one quotient bit per cycle; signed support with DIVIDER_SIGNED_EN.
module divider_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = cnt_width(WIDTH);
  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, dvd, dsr, rem_next, a_mag, b_mag, q_fin, q_out, r_out;
  logic             q_bit, neg_q, neg_r, sa, sb;
`ifdef DIVIDER_SIGNED_EN
  assign sa = signed_op & dividend[WIDTH-1];
  assign sb = signed_op & divisor[WIDTH-1];
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
`endif
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .dvd_msb (dvd[WIDTH-1]),
    .divisor (dsr),
    .rem_next(rem_next),
    .q_bit   (q_bit)
  );
  // A zero divisor keeps the quotient un-negated so it stays all ones and the remainder equals the dividend.
  always_comb begin
    a_mag = sa ? -dividend : dividend;
    b_mag = sb ? -divisor : divisor;
    q_fin = {dvd[WIDTH-2:0], q_bit};
    q_out = neg_q ? -q_fin : q_fin;
    r_out = neg_r ? -rem_next : rem_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_IDLE;
      cnt       <= '0;
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        DIV_BUSY: begin
          rem <= rem_next;
          dvd <= q_fin;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            quotient  <= q_out;
            remainder <= r_out;
            div_zero  <= dsr == '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DIV_DONE;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            rem   <= '0;
            dvd   <= a_mag;
            dsr   <= b_mag;
            cnt   <= CW'(WIDTH);
            neg_q <= (sa ^ sb) & (|divisor);
            neg_r <= sa;
            busy  <= 1'b1;
            state <= DIV_BUSY;
          end else begin
            state <= DIV_IDLE;
          end
        end
      endcase
    end
  end
endmodule
